// File: rtl/div_pkg.sv
// Shared divider definitions: FSM state encoding and div_op bit positions
// (the op bit indices are also used by the multiplier).
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } div_state_e;

  localparam int unsigned DIV_OP_SGN  = 0;
  localparam int unsigned DIV_OP_USGN = 1;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and shift the resulting quotient bit in.
module div_restore_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  assign partial = {rem_i, quo_i[WIDTH-1]};
  assign diff    = partial - {1'b0, dvs_i};

  // diff[WIDTH] is the borrow: restore the partial remainder and shift in 0.
  assign rem_o = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, result held until consumed.
// Define ITER_DIV_CANCEL_EN to let div_cancel abort an operation in any state.
module iter_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           div_op,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  input  logic                 div_in_valid,
  output logic                 div_in_ready,
  input  logic                 div_cancel,
  output logic [2*WIDTH-1:0]   div_result,
  output logic                 div_out_valid,
  input  logic                 div_out_ready
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(1);

  div_state_e         state_q;
  logic [CntW-1:0]    cnt_q;
  logic               sgn_q;
  logic               dend_neg_q;
  logic               dvs_neg_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [2*WIDTH-1:0] result_q;
  logic               out_valid_q;

  logic               cancel;
  logic               accept;
  logic               op_sgn;
  logic [WIDTH-1:0]   dend_abs;
  logic [WIDTH-1:0]   dvs_abs;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               unused_op;

`ifdef ITER_DIV_CANCEL_EN
  assign cancel = div_cancel;
`else
  logic unused_cancel;
  assign unused_cancel = div_cancel;
  assign cancel        = 1'b0;
`endif

  // Only bit 0 matters: 2'b11 is signed, 2'b00 is unsigned.
  assign unused_op = div_op[DIV_OP_USGN];
  assign op_sgn    = div_op[DIV_OP_SGN];

  assign div_in_ready  = (state_q == StIdle) && !cancel;
  assign accept        = div_in_valid && div_in_ready;
  assign div_out_valid = out_valid_q;
  assign div_result    = result_q;

  always_comb begin
    dend_abs = (op_sgn && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_abs  = (op_sgn && divisor[WIDTH-1])  ? -divisor  : divisor;
    quo_fix  = (sgn_q && (dend_neg_q ^ dvs_neg_q)) ? -quo_q : quo_q;
    rem_fix  = (sgn_q && dend_neg_q) ? -rem_q : rem_q;
  end

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dvs_i(dvs_q),
    .rem_o(step_rem),
    .quo_o(step_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      dend_neg_q  <= 1'b0;
      dvs_neg_q   <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (cancel) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q    <= StCalc;
            cnt_q      <= CntInit;
            sgn_q      <= op_sgn;
            dend_neg_q <= dividend[WIDTH-1];
            dvs_neg_q  <= divisor[WIDTH-1];
            rem_q      <= '0;
            quo_q      <= dend_abs;
            dvs_q      <= dvs_abs;
          end
        end
        StCalc: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q - CntLast;
          if (cnt_q == CntLast) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          result_q    <= {rem_fix, quo_fix};
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (div_out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/iter_divider.md
# iter_divider

Parametrised, native multi-cycle restoring divider for the execute stage. It replaces the vendor divider cores and their AXI-stream glue for DIV/DIVU. Operands are captured on a valid/ready accept, the block iterates one quotient bit per cycle, and it holds `{remainder, quotient}` until the stage consumes it. It adds three behaviours the previous block lacked: width is a parameter, operands need not be held after accept, and an in-flight operation can be cancelled on pipeline flush.

## Interface
- `WIDTH`, default 32: operand width. Must be ≥ 2.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `div_op`  in  2: operation select. Bit 0 selects signed; otherwise the operation is unsigned. Sampled only at accept.
- `dividend`  in  WIDTH: dividend, sampled at accept.
- `divisor`  in  WIDTH: divisor, sampled at accept.
- `div_in_valid`  in  1: request valid.
- `div_in_ready`  out  1: block can accept a request.
- `div_cancel`  in  1: abort the current operation. Active only with `ITER_DIV_CANCEL_EN`.
- `div_result`  out  2*WIDTH: `{remainder, quotient}`. Remainder is in the upper half (HI) and quotient in the lower half (LO).
- `div_out_valid`  out  1: result valid.
- `div_out_ready`  in  1: consumer takes the result.

## Operation
- States and transitions:
  - IDLE → CALC on accept.
  - CALC runs for WIDTH cycles, driven by a down-counter of width `$clog2(WIDTH+1)`, then → FIX.
  - FIX → DONE.
  - DONE → IDLE on the output handshake.
- Accept occurs when `div_in_valid && div_in_ready`. At accept the block registers:
  - the sign mode,
  - the sign of the dividend and the sign of the divisor,
  - |dividend| and |divisor|, where abs applies only in signed mode.
- CALC performs a restoring step: `partial = {rem, quo_msb}`; trial subtract of |divisor| on WIDTH+1 bits; on no borrow, keep the difference and shift in quotient bit 1, otherwise shift in 0.
- FIX applies signs in signed mode:
  - the quotient is negated if sign(dividend) ^ sign(divisor);
  - the remainder takes the sign of the dividend.
- FIX then registers `div_result`.
- Results are as produced by the algorithm. There are no traps and the outputs are never X.
  - Divide by zero: magnitude quotient is all-ones and magnitude remainder is |dividend|, then FIX applies. Unsigned 5/0 gives q=0xFFFFFFFF, r=5. Signed -7/0 gives q=1, r=-7.
  - Signed MIN/-1 gives q=MIN, r=0, with the quotient wrapping to WIDTH bits.
- `div_result` is stable for the whole of DONE and keeps its last value after the handshake until the next FIX.
- `div_op` values 2'b00 and 2'b11 are treated by bit 0 only.

## Timing
- Reset values:
  - state = IDLE
  - `div_in_ready` = 1
  - `div_out_valid` = 0
  - `div_result` = 0
  - counter = 0
- `div_in_ready` = (state == IDLE), ANDed with `!div_cancel` when cancel is compiled in. It is combinational from state and cancel only.
- `div_out_valid` = (state == DONE), driven from a register.
- Latency: for an accept at edge t, `div_out_valid` rises after edge t+WIDTH+1. For WIDTH=32 that is 33 cycles.
- Throughput: there is no overlap. The next accept is possible at the earliest in the cycle after the output handshake, because IDLE is re-entered at that edge.
- Backpressure: with `div_out_ready` low, DONE persists indefinitely with the result unchanged and `div_in_ready` low.
- `div_in_valid` while the block is busy is ignored. It is neither queued nor sampled.
- Reset mid-operation: the block returns immediately to reset values. No result is emitted.

## Configuration
- `ITER_DIV_CANCEL_EN` defined:
  - `div_cancel` high in any state forces IDLE at the next edge.
  - `div_out_valid` drops at that edge and the result is discarded.
  - If cancel and an accept coincide, cancel wins: `div_in_ready` is masked low, so the accept never happens.
  - Cancel in DONE together with `div_out_ready` counts as a cancel, not a consumption.
- Undefined: `div_cancel` is ignored. The port still exists and is tied off by the parent.

## Structure
- Shared package `div_pkg`:
  - state enum IDLE/CALC/FIX/DONE;
  - op bit indices `DIV_OP_SGN=0` and `DIV_OP_USGN=1`, which are also used by the multiplier.
- One sub-module, `div_restore_step`: a combinational single iteration. It takes partial remainder, partial quotient and divisor, and returns the next remainder and quotient. It is parametrised by WIDTH and instantiated once.

## Test plan
- Unsigned divide, WIDTH=32: 100/7, op=2'b10 → q=14, r=2, `div_out_valid` exactly 33 cycles after accept.
- Signed divide: -7/2 → q=0xFFFFFFFD, r=0xFFFFFFFF; 7/-2 → q=0xFFFFFFFD, r=1; MIN/-1 → q=0x80000000, r=0.
- Divide by zero: unsigned 5/0 → q=0xFFFFFFFF, r=5; signed -7/0 → q=1, r=0xFFFFFFF9.
- Backpressure and busy input:
  - hold `div_out_ready` low 10 cycles after valid → result stable, `div_in_ready` low;
  - toggle `div_in_valid` with new operands during CALC → ignored;
  - after the handshake, a new request is accepted the next cycle.
- Cancel (`ITER_DIV_CANCEL_EN`):
  - pulse `div_cancel` 10 cycles into CALC → no `div_out_valid`, `div_in_ready` high the next cycle, next op 9/3 → q=3, r=0;
  - cancel coinciding with `div_in_valid` in IDLE → no accept.
- Reset and width sweep:
  - assert `rst_n` low mid-CALC → outputs at reset values, then the next op is correct;
  - repeat with WIDTH=8: 200/13 unsigned → q=15, r=5 after 9 cycles.
